// File: rtl/bytecode_pkg.sv
// Shared types and constants for the bytecode program image format.
package bytecode_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned KIND_W = 4;
    localparam int unsigned LEN_W  = 3;

    typedef enum logic [KIND_W-1:0] {
        KIND_ALU2  = 4'd0,
        KIND_ALU1  = 4'd1,
        KIND_STI   = 4'd2,
        KIND_MOV   = 4'd3,
        KIND_PRINT = 4'd4,
        KIND_JMP   = 4'd5,
        KIND_BRA   = 4'd6,
        KIND_RET   = 4'd7,
        KIND_HALT  = 4'd8
    } kind_t;

    localparam logic [BYTE_W-1:0] OP_ALU2       = 8'h02;
    localparam logic [BYTE_W-1:0] OP_ALU1       = 8'h01;
    localparam logic [BYTE_W-1:0] OP_STI        = 8'hC2;
    localparam logic [BYTE_W-1:0] OP_MOV        = 8'hE2;
    localparam logic [BYTE_W-1:0] OP_PRINT      = 8'h81;
    localparam logic [BYTE_W-1:0] OP_JMP        = 8'hAA;
    localparam logic [BYTE_W-1:0] OP_BRA        = 8'hDA;
    localparam logic [BYTE_W-1:0] OP_RET        = 8'h55;
    localparam logic [BYTE_W-1:0] OP_HALT       = 8'hFF;
    localparam logic [BYTE_W-1:0] START_MARK    = 8'h7E;
    localparam logic [BYTE_W-1:0] TERMINAL_LINE = 8'hFF;

    // Operand fields of one instruction request, emitted f0 first.
    typedef struct packed {
        logic [BYTE_W-1:0] f2;
        logic [BYTE_W-1:0] f1;
        logic [BYTE_W-1:0] f0;
    } fields_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_ACCEPT,
        ST_EMIT,
        ST_HALT,
        ST_DONE,
        ST_ERR
    } state_t;

    // Operand byte for emit position idx (1 = f0, 2 = f1, 3 = f2).
    function automatic logic [BYTE_W-1:0] field_sel(input fields_t f, input logic [LEN_W-1:0] idx);
        logic [BYTE_W-1:0] b;
        b = f.f0;
        if (idx == LEN_W'(2)) b = f.f1;
        if (idx == LEN_W'(3)) b = f.f2;
        return b;
    endfunction

endpackage

// File: rtl/bytecode_format.sv
// Instruction kind decode: opcode, total byte length and legality.
module bytecode_format
    import bytecode_pkg::*;
(
    input  logic [KIND_W-1:0] kind,
    output logic [BYTE_W-1:0] opcode_c,
    output logic [LEN_W-1:0]  len_c,
    output logic              valid_c
);

    // Table lookup; unknown kinds decode as invalid with zero length.
    always_comb begin
        opcode_c = '0;
        len_c    = '0;
        valid_c  = 1'b0;
        case (kind)
            KIND_ALU2:  begin opcode_c = OP_ALU2;  len_c = LEN_W'(4); valid_c = 1'b1; end
            KIND_ALU1:  begin opcode_c = OP_ALU1;  len_c = LEN_W'(3); valid_c = 1'b1; end
            KIND_STI:   begin opcode_c = OP_STI;   len_c = LEN_W'(3); valid_c = 1'b1; end
            KIND_MOV:   begin opcode_c = OP_MOV;   len_c = LEN_W'(3); valid_c = 1'b1; end
            KIND_PRINT: begin opcode_c = OP_PRINT; len_c = LEN_W'(2); valid_c = 1'b1; end
            KIND_JMP:   begin opcode_c = OP_JMP;   len_c = LEN_W'(2); valid_c = 1'b1; end
            KIND_BRA:   begin opcode_c = OP_BRA;   len_c = LEN_W'(2); valid_c = 1'b1; end
            KIND_RET:   begin opcode_c = OP_RET;   len_c = LEN_W'(1); valid_c = 1'b1; end
            KIND_HALT:  begin opcode_c = OP_HALT;  len_c = LEN_W'(1); valid_c = 1'b1; end
            default:    ;
        endcase
    end

endmodule

// File: rtl/bytecode_emitter.sv
// Serializes instruction requests into a marker-framed, halt-terminated byte image.
module bytecode_emitter
    import bytecode_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned MAX_LEN = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [KIND_W-1:0] in_kind,
    input  logic [BYTE_W-1:0] in_f0,
    input  logic [BYTE_W-1:0] in_f1,
    input  logic [BYTE_W-1:0] in_f2,
    input  logic              finish,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [BYTE_W-1:0] wr_data,
    output logic              done,
    output logic              err,
    output logic [BYTE_W-1:0] prog_len
);

    // Wide enough for prog_len + instruction length + reserved halt byte.
    localparam int unsigned CHK_W = 10;

    state_t             state;
    fields_t            cap_f;
    logic [LEN_W-1:0]   cap_len;
    logic [LEN_W-1:0]   sent;
    logic               cap_halt;

    logic [BYTE_W-1:0]  fmt_op_c;
    logic [LEN_W-1:0]   fmt_len_c;
    logic               fmt_valid_c;
    logic               fits_c;

    bytecode_format u_format (
        .kind     (in_kind),
        .opcode_c (fmt_op_c),
        .len_c    (fmt_len_c),
        .valid_c  (fmt_valid_c)
    );

    // The request plus one reserved halt byte must fit in the image.
    assign fits_c = (CHK_W'(prog_len) + CHK_W'(fmt_len_c) + CHK_W'(1)) <= CHK_W'(MAX_LEN);

    // Control FSM; outputs are registered so they line up with the state entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            in_ready <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            prog_len <= '0;
            cap_f    <= '0;
            cap_len  <= '0;
            sent     <= '0;
            cap_halt <= 1'b0;
        end else begin
            // A write on the bus this cycle is committed at this edge.
            if (wr_en) prog_len <= prog_len + BYTE_W'(1);

            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state    <= ST_MARK;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        prog_len <= '0;
                        wr_en    <= 1'b1;
                        wr_addr  <= '0;
                        wr_data  <= START_MARK;
                    end
                end
                ST_MARK: begin
                    wr_en    <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= ST_ACCEPT;
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        cap_f    <= '{f2: in_f2, f1: in_f1, f0: in_f0};
                        cap_len  <= fmt_len_c;
                        cap_halt <= (in_kind == KIND_HALT);
                        if (!fmt_valid_c || !fits_c) begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end else begin
                            state   <= ST_EMIT;
                            wr_en   <= 1'b1;
                            wr_addr <= ADDR_W'(prog_len);
                            wr_data <= fmt_op_c;
                            sent    <= LEN_W'(1);
                        end
                    end else if (finish) begin
                        in_ready <= 1'b0;
                        state    <= ST_HALT;
                        wr_en    <= 1'b1;
                        wr_addr  <= ADDR_W'(prog_len);
                        wr_data  <= TERMINAL_LINE;
                    end
                end
                ST_EMIT: begin
                    if (sent < cap_len) begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                        wr_data <= field_sel(cap_f, sent);
                        sent    <= sent + LEN_W'(1);
                    end else begin
                        wr_en <= 1'b0;
                        if (cap_halt) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_ACCEPT;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    wr_en <= 1'b0;
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bytecode_emitter.sv
// Directed bench: one full-size emitter and one with an 8-byte image limit, sharing stimulus.
module tb_bytecode_emitter;
    import bytecode_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [3:0] in_kind;
    logic [7:0] in_f0, in_f1, in_f2;
    logic       finish;

    logic       b_in_ready, b_wr_en, b_done, b_err;
    logic [7:0] b_wr_addr, b_wr_data, b_prog_len;
    logic       s_in_ready, s_wr_en, s_done, s_err;
    logic [7:0] s_wr_addr, s_wr_data, s_prog_len;

    int checks = 0;
    int errors = 0;
    int b_wcnt = 0;
    int s_wcnt = 0;

    bytecode_emitter u_big (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_kind(in_kind), .in_f0(in_f0), .in_f1(in_f1), .in_f2(in_f2), .finish(finish),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .done(b_done), .err(b_err), .prog_len(b_prog_len)
    );

    bytecode_emitter #(.ADDR_W(8), .MAX_LEN(8)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_kind(in_kind), .in_f0(in_f0), .in_f1(in_f1), .in_f2(in_f2), .finish(finish),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .done(s_done), .err(s_err), .prog_len(s_prog_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count committed writes so duplicates or stray writes show up.
    always @(posedge clk) begin
        if (b_wr_en) b_wcnt <= b_wcnt + 1;
        if (s_wr_en) s_wcnt <= s_wcnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input string tag, input logic [7:0] addr, input logic [7:0] data);
        chk({tag, ".wr_en"}, 32'(b_wr_en), 32'd1);
        chk({tag, ".wr_addr"}, 32'(b_wr_addr), 32'(addr));
        chk({tag, ".wr_data"}, 32'(b_wr_data), 32'(data));
    endtask

    task automatic req(input logic [3:0] k, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        in_valid = 1'b1;
        in_kind  = k;
        in_f0    = a;
        in_f1    = b;
        in_f2    = c;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_kind = '0;
        in_f0 = '0; in_f1 = '0; in_f2 = '0; finish = 1'b0;
        #2;
        chk("rst.wr_en", 32'(b_wr_en), 32'd0);
        chk("rst.wr_addr", 32'(b_wr_addr), 32'd0);
        chk("rst.wr_data", 32'(b_wr_data), 32'd0);
        chk("rst.in_ready", 32'(b_in_ready), 32'd0);
        chk("rst.done", 32'(b_done), 32'd0);
        chk("rst.err", 32'(b_err), 32'd0);
        chk("rst.prog_len", 32'(b_prog_len), 32'd0);
        #10 rst_n = 1'b1;

        // Basic image: 7E 02 01 05 03 FF
        start = 1'b1; tick(); start = 1'b0;
        expect_wr("t1.mark", 8'h00, 8'h7E);
        tick();
        chk("t1.ready", 32'(b_in_ready), 32'd1);
        chk("t1.len_after_mark", 32'(b_prog_len), 32'd1);
        req(KIND_ALU2, 8'h01, 8'h05, 8'h03); tick(); in_valid = 1'b0;
        expect_wr("t1.op", 8'h01, 8'h02);
        chk("t1.ready_emit", 32'(b_in_ready), 32'd0);
        tick(); expect_wr("t1.f0", 8'h02, 8'h01);
        tick(); expect_wr("t1.f1", 8'h03, 8'h05);
        tick(); expect_wr("t1.f2", 8'h04, 8'h03);
        tick();
        chk("t1.back_accept", 32'(b_in_ready), 32'd1);
        chk("t1.len5", 32'(b_prog_len), 32'd5);
        finish = 1'b1; tick(); finish = 1'b0;
        expect_wr("t1.halt", 8'h05, 8'hFF);
        tick();
        chk("t1.done", 32'(b_done), 32'd1);
        chk("t1.err", 32'(b_err), 32'd0);
        chk("t1.len6", 32'(b_prog_len), 32'd6);
        chk("t1.idle_wr", 32'(b_wr_en), 32'd0);
        chk("t1.wcnt", 32'(b_wcnt), 32'd6);

        // Back-pressure: STI held valid through the ALU2 emit; small unit overflows on it
        start = 1'b1; tick(); start = 1'b0;
        expect_wr("t2.mark", 8'h00, 8'h7E);
        chk("t2.done_clr", 32'(b_done), 32'd0);
        chk("t2.len_clr", 32'(b_prog_len), 32'd0);
        tick();
        req(KIND_ALU2, 8'h01, 8'h05, 8'h03); tick();
        expect_wr("t2.op", 8'h01, 8'h02);
        req(KIND_STI, 8'h07, 8'h2A, 8'h00);
        tick(); expect_wr("t2.f0", 8'h02, 8'h01);
        chk("t2.ready_low1", 32'(b_in_ready), 32'd0);
        tick(); expect_wr("t2.f1", 8'h03, 8'h05);
        chk("t2.ready_low2", 32'(b_in_ready), 32'd0);
        tick(); expect_wr("t2.f2", 8'h04, 8'h03);
        chk("t2.ready_low3", 32'(b_in_ready), 32'd0);
        tick();
        chk("t2.accept", 32'(b_in_ready), 32'd1);
        chk("t2.accept_nowr", 32'(b_wr_en), 32'd0);
        tick(); in_valid = 1'b0;
        expect_wr("t2.sti_op", 8'h05, 8'hC2);
        chk("t2.s_err", 32'(s_err), 32'd1);
        chk("t2.s_nowr", 32'(s_wr_en), 32'd0);
        chk("t2.s_len", 32'(s_prog_len), 32'd5);
        tick(); expect_wr("t2.sti_f0", 8'h06, 8'h07);
        tick(); expect_wr("t2.sti_f1", 8'h07, 8'h2A);
        tick();
        chk("t2.len8", 32'(b_prog_len), 32'd8);
        finish = 1'b1; tick(); finish = 1'b0;
        expect_wr("t2.halt", 8'h08, 8'hFF);
        tick();
        chk("t2.done", 32'(b_done), 32'd1);
        chk("t2.len9", 32'(b_prog_len), 32'd9);
        chk("t2.wcnt", 32'(b_wcnt), 32'd15);
        chk("t2.s_wcnt", 32'(s_wcnt), 32'd11);
        chk("t2.s_err_held", 32'(s_err), 32'd1);
        chk("t2.s_len_held", 32'(s_prog_len), 32'd5);

        // Control flow plus simultaneous in_valid/finish; start clears the small unit's error
        start = 1'b1; tick(); start = 1'b0;
        expect_wr("t3.mark", 8'h00, 8'h7E);
        chk("t3.s_err_clr", 32'(s_err), 32'd0);
        chk("t3.s_mark_en", 32'(s_wr_en), 32'd1);
        chk("t3.s_mark_addr", 32'(s_wr_addr), 32'd0);
        chk("t3.s_mark_data", 32'(s_wr_data), 32'h7E);
        tick();
        req(KIND_JMP, 8'h10, 8'h00, 8'h00); tick(); in_valid = 1'b0;
        expect_wr("t3.jmp", 8'h01, 8'hAA);
        tick(); expect_wr("t3.jmp_t", 8'h02, 8'h10);
        tick();
        req(KIND_RET, 8'h00, 8'h00, 8'h00); tick(); in_valid = 1'b0;
        expect_wr("t3.ret", 8'h03, 8'h55);
        tick();
        req(KIND_PRINT, 8'h06, 8'h00, 8'h00); finish = 1'b1; tick(); in_valid = 1'b0;
        expect_wr("t3.print", 8'h04, 8'h81);
        tick(); expect_wr("t3.print_a", 8'h05, 8'h06);
        tick();
        chk("t3.accept", 32'(b_in_ready), 32'd1);
        tick(); finish = 1'b0;
        expect_wr("t3.halt", 8'h06, 8'hFF);
        tick();
        chk("t3.done", 32'(b_done), 32'd1);
        chk("t3.len7", 32'(b_prog_len), 32'd7);
        chk("t3.s_done", 32'(s_done), 32'd1);
        chk("t3.wcnt", 32'(b_wcnt), 32'd22);
        chk("t3.s_wcnt", 32'(s_wcnt), 32'd18);

        // start ignored during EMIT, then an unknown kind errors without writing
        start = 1'b1; tick(); start = 1'b0;
        tick();
        req(KIND_ALU2, 8'h09, 8'h08, 8'h07); tick(); in_valid = 1'b0;
        expect_wr("t4.op", 8'h01, 8'h02);
        start = 1'b1; tick(); start = 1'b0;
        expect_wr("t4.f0_not_restart", 8'h02, 8'h09);
        tick(); tick(); tick();
        chk("t4.accept", 32'(b_in_ready), 32'd1);
        req(4'hF, 8'h00, 8'h00, 8'h00); tick(); in_valid = 1'b0;
        chk("t4.err", 32'(b_err), 32'd1);
        chk("t4.nowr", 32'(b_wr_en), 32'd0);
        chk("t4.ready", 32'(b_in_ready), 32'd0);
        chk("t4.len", 32'(b_prog_len), 32'd5);
        tick();
        chk("t4.err_held", 32'(b_err), 32'd1);
        chk("t4.wcnt", 32'(b_wcnt), 32'd27);

        // Reset during the third ALU2 byte
        start = 1'b1; tick(); start = 1'b0;
        tick();
        req(KIND_ALU2, 8'h01, 8'h05, 8'h03); tick(); in_valid = 1'b0;
        tick(); tick();
        expect_wr("t5.third", 8'h03, 8'h05);
        rst_n = 1'b0; #1;
        chk("t5.wr_en", 32'(b_wr_en), 32'd0);
        chk("t5.wr_addr", 32'(b_wr_addr), 32'd0);
        chk("t5.wr_data", 32'(b_wr_data), 32'd0);
        chk("t5.len", 32'(b_prog_len), 32'd0);
        chk("t5.err", 32'(b_err), 32'd0);
        chk("t5.done", 32'(b_done), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("t5.ready0", 32'(b_in_ready), 32'd0);
        chk("t5.nowr", 32'(b_wr_en), 32'd0);
        tick();
        chk("t5.ready1", 32'(b_in_ready), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        expect_wr("t5.mark", 8'h00, 8'h7E);
        tick();
        chk("t5.ready_after_start", 32'(b_in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
